// File: rtl/vec_idx_extractor_pkg.sv
// vec_idx_extractor shared constants and state encoding.
// Geometry: 70 segments x 14 groups x 10 bits.
package vec_idx_extractor_pkg;

  localparam int N_BITS   = 9800;
  localparam int SEG_BITS = 140;
  localparam int GRP_BITS = 10;
  localparam int N_SEG    = 70;
  localparam int N_GRP    = 14;
  localparam int IDX_W    = 14;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_SEG,
    SCAN_GRP,
    SCAN_BIT,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/vec_seg_select.sv
// Segment slice selection and any-bit reduction
// for the sparse index extractor.
module vec_seg_select #(
  parameter int N_BITS   = 9800,
  parameter int SEG_BITS = 140,
  parameter int GRP_BITS = 10,
  parameter int N_SEG    = N_BITS / SEG_BITS,
  parameter int N_GRP    = SEG_BITS / GRP_BITS
) (
  input  logic [0:N_BITS-1]   work,
  input  logic [6:0]          seg_ptr,
  output logic [SEG_BITS-1:0] seg,
  output logic                seg_any,
  output logic [N_GRP-1:0]    grp_any
);
  import vec_idx_extractor_pkg::*;

  localparam logic [6:0] SEG_CNT = 7'(N_SEG);

  // seg[k] is vector bit seg_ptr*SEG_BITS + k
  logic [SEG_BITS-1:0] segs [N_SEG];

  for (genvar s = 0; s < N_SEG; s++) begin : g_seg
    for (genvar k = 0; k < SEG_BITS; k++) begin : g_bit
      assign segs[s][k] = work[s*SEG_BITS+k];
    end
  end

  always_comb begin
    seg = '0;
    if (seg_ptr < SEG_CNT) seg = segs[seg_ptr];
  end

  assign seg_any = |seg;

  for (genvar g = 0; g < N_GRP; g++) begin : g_grp
    assign grp_any[g] = |seg[g*GRP_BITS +: GRP_BITS];
  end

endmodule

// File: rtl/vec_idx_extractor.sv
// Sparse bit-vector decoder: emits the index of every set
// bit in ascending order over a valid/ready handshake.
module vec_idx_extractor #(
  parameter int N_BITS   = 9800,
  parameter int SEG_BITS = 140,
  parameter int GRP_BITS = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [0:N_BITS-1]                      vector,
  output logic [vec_idx_extractor_pkg::IDX_W-1:0] idx,
  output logic                                   idx_valid,
  input  logic                                   idx_ready,
  output logic                                   busy,
  output logic                                   done,
  output logic [vec_idx_extractor_pkg::IDX_W-1:0] count
);
  import vec_idx_extractor_pkg::*;

  localparam int NSEG = N_BITS / SEG_BITS;
  localparam int NGRP = SEG_BITS / GRP_BITS;
  localparam logic [6:0] LAST_SEG = 7'(NSEG - 1);
  localparam logic [3:0] LAST_GRP = 4'(NGRP - 1);
  localparam logic [7:0] GRP_W8 = 8'(GRP_BITS);
  localparam logic [IDX_W-1:0] SEG_WI = IDX_W'(SEG_BITS);

  state_t state, nxt;
  logic [0:N_BITS-1] work;
  logic [6:0] seg_ptr;
  logic [3:0] grp_ptr, bit_ptr;
  logic [7:0] boff;
  logic [SEG_BITS-1:0] seg;
  logic [NGRP-1:0] grp_any;
  logic seg_any, grp_hit, cur_bit;
  logic last_seg, last_grp;

  vec_seg_select #(
    .N_BITS  (N_BITS),
    .SEG_BITS(SEG_BITS),
    .GRP_BITS(GRP_BITS)
  ) u_sel (
    .work   (work),
    .seg_ptr(seg_ptr),
    .seg    (seg),
    .seg_any(seg_any),
    .grp_any(grp_any)
  );

  // Index comes from registered pointers only
  assign boff = {4'd0, grp_ptr} * GRP_W8 + {4'd0, bit_ptr};
  assign idx  = {7'd0, seg_ptr} * SEG_WI + {6'd0, boff};

  assign grp_hit   = grp_any[grp_ptr];
  assign cur_bit   = seg[boff];
  assign last_seg  = (seg_ptr == LAST_SEG);
  assign last_grp  = (grp_ptr == LAST_GRP);
  assign idx_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (start) nxt = SCAN_SEG;
      SCAN_SEG: begin
        if (seg_any)       nxt = SCAN_GRP;
        else if (last_seg) nxt = DONE;
      end
      SCAN_GRP: begin
        if (grp_hit)       nxt = SCAN_BIT;
        else if (last_grp) nxt = last_seg ? DONE : SCAN_SEG;
      end
      SCAN_BIT: if (cur_bit) nxt = EMIT;
      EMIT:     if (idx_ready) nxt = SCAN_GRP;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      work    <= '0;
      seg_ptr <= '0;
      grp_ptr <= '0;
      bit_ptr <= '0;
      count   <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (start) begin
          work    <= vector;
          count   <= '0;
          seg_ptr <= '0;
          grp_ptr <= '0;
          bit_ptr <= '0;
        end
        SCAN_SEG: begin
          if (seg_any)        grp_ptr <= '0;
          else if (!last_seg) seg_ptr <= seg_ptr + 7'd1;
        end
        SCAN_GRP: begin
          if (grp_hit)        bit_ptr <= '0;
          else if (!last_grp) grp_ptr <= grp_ptr + 4'd1;
          else if (!last_seg) seg_ptr <= seg_ptr + 7'd1;
        end
        SCAN_BIT: if (!cur_bit) bit_ptr <= bit_ptr + 4'd1;
        // Clearing the emitted bit lets SCAN_GRP re-test the group
        EMIT: if (idx_ready) begin
          work[idx] <= 1'b0;
          count     <= count + 14'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_idx_extractor.sv
// Self-checking bench for vec_idx_extractor: vector table
// plus hold, busy-start and reset corner sequences.
module tb_vec_idx_extractor;
  localparam int N = 9800;

  logic clk = 1'b0;
  logic rst, start, idx_ready, idx_valid, busy, done;
  logic [0:N-1] vector;
  logic [13:0] idx, count;

  always #5 clk = ~clk;

  vec_idx_extractor dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vector   (vector),
    .idx      (idx),
    .idx_valid(idx_valid),
    .idx_ready(idx_ready),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  typedef struct {
    int nb;
    int b[5];
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_v = -1;
  int done_c = -1;
  int exp_cnt = 0;
  bit rnd_rdy = 1'b0;
  int exp_q[$];
  vec_t tv[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [0:N-1] build(input vec_t t);
    logic [0:N-1] v;
    v = '0;
    for (int i = 0; i < t.nb; i++) v[t.b[i]] = 1'b1;
    return v;
  endfunction

  task automatic observe();
    if (idx_valid) begin
      if (first_v < 0) first_v = cyc;
      if (exp_q.size() == 0) chk("spurious_valid", int'(idx), -1);
      else if (idx_ready) chk("idx", int'(idx), exp_q.pop_front());
    end
    if (done && done_c < 0) done_c = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rnd_rdy) idx_ready = 1'($urandom_range(0, 1));
    observe();
  endtask

  // Expected indices are the set bits in ascending order
  task automatic launch(input logic [0:N-1] v);
    for (int i = 0; i < N; i++) if (v[i]) exp_q.push_back(i);
    exp_cnt = exp_q.size();
    @(negedge clk);
    vector = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    vector = '1;
    cyc = 1;
    first_v = -1;
    done_c = -1;
    observe();
  endtask

  task automatic finish_run(input string nm, input int budget);
    while (done_c < 0 && cyc < budget) step();
    chk({nm, "_done_seen"}, int'(done_c >= 0), 1);
    chk({nm, "_count"}, int'(count), exp_cnt);
    chk({nm, "_leftover"}, exp_q.size(), 0);
    step();
    chk({nm, "_done_pulse"}, int'(done), 0);
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    logic [0:N-1] rv;
    rst = 1'b1;
    start = 1'b0;
    idx_ready = 1'b1;
    vector = '0;
    repeat (2) @(negedge clk);
    chk("rst_idx", int'(idx), 0);
    chk("rst_valid", int'(idx_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    rst = 1'b0;

    tv[0] = '{1, '{0, 0, 0, 0, 0}};
    tv[1] = '{1, '{9799, 0, 0, 0, 0}};
    tv[2] = '{5, '{0, 10, 139, 140, 9790}};
    tv[3] = '{0, '{0, 0, 0, 0, 0}};
    tv[4] = '{3, '{9, 10, 9789, 0, 0}};
    tv[5] = '{2, '{138, 139, 0, 0, 0}};
    tv[6] = '{4, '{1, 2, 3, 4000, 0}};

    for (int r = 0; r < 7; r++) begin
      launch(build(tv[r]));
      finish_run($sformatf("vec%0d", r), 1000);
      if (r == 0) chk("lat_bit0", first_v, 4);
      if (r == 3) begin
        chk("zero_done_cyc", done_c, 71);
        chk("zero_no_valid", first_v, -1);
      end
    end

    repeat (3) step();
    chk("count_hold", int'(count), 4);

    // Random vector with random consumer stalls
    rv = '0;
    for (int i = 0; i < 8; i++) rv[$urandom_range(0, N - 1)] = 1'b1;
    rnd_rdy = 1'b1;
    launch(rv);
    finish_run("rand", 3000);
    rnd_rdy = 1'b0;
    idx_ready = 1'b1;

    // Back-pressure hold, plus a start issued while busy
    idx_ready = 1'b0;
    launch(build('{2, '{5, 6, 0, 0, 0}}));
    while (!idx_valid && cyc < 50) step();
    chk("hold_reach", int'(idx_valid), 1);
    for (int i = 0; i < 8; i++) begin
      chk("hold_idx", int'(idx), 5);
      chk("hold_valid", int'(idx_valid), 1);
      if (i == 2) start = 1'b1;
      step();
      start = 1'b0;
    end
    idx_ready = 1'b1;
    observe();
    finish_run("hold", 1000);

    // Reset while emitting 140
    idx_ready = 1'b0;
    launch(build('{2, '{140, 141, 0, 0, 0}}));
    while (!idx_valid && cyc < 100) step();
    chk("pre_rst_idx", int'(idx), 140);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", int'(idx_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(count), 0);
    rst = 1'b0;
    exp_q.delete();
    idx_ready = 1'b1;
    launch(build('{1, '{3, 0, 0, 0, 0}}));
    finish_run("post_rst", 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_idx_extractor.md
VEC_IDX_EXTRACTOR -- requirements
Module: vec_idx_extractor

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters SHALL be: N_BITS, default 9800, vector length; SEG_BITS, default 140, segment width; GRP_BITS, default 10, group width.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  single-cycle request to decode vector; honoured only in IDLE.
REQ-006 Port: vector  input  [0:N_BITS-1]  sparse vector; bit 0 maps to index 0. Sampled only on the accepted start cycle.
REQ-007 Port: idx  output  14  index of the current set bit.
REQ-008 Port: idx_valid  output  1  idx is valid.
REQ-009 Port: idx_ready  input  1  consumer accepts idx.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle pulse at scan completion.
REQ-012 Port: count  output  14  number of indices emitted; valid while done is high.

Function
REQ-013 A start sampled in IDLE SHALL copy vector into an internal working register, clear count, set seg_ptr/grp_ptr/bit_ptr to 0, and enter SCAN_SEG on the next cycle.
REQ-014 States SHALL be IDLE, SCAN_SEG, SCAN_GRP, SCAN_BIT, EMIT, DONE.
REQ-015 SCAN_SEG SHALL test segment seg_ptr (bits seg_ptr*140 .. +139): non-zero -> SCAN_GRP with grp_ptr=0; zero with seg_ptr<69 -> seg_ptr+1; zero with seg_ptr=69 -> DONE.
REQ-016 SCAN_GRP SHALL test group grp_ptr of the current segment: non-zero -> SCAN_BIT with bit_ptr=0; zero with grp_ptr<13 -> grp_ptr+1; zero with grp_ptr=13 -> SCAN_SEG with seg_ptr+1, or DONE if seg_ptr=69.
REQ-017 SCAN_BIT SHALL test bit bit_ptr: set -> EMIT; clear -> bit_ptr+1. bit_ptr SHALL never exceed 9 because the group is non-zero.
REQ-018 In EMIT, idx SHALL equal seg_ptr*140 + grp_ptr*10 + bit_ptr (14-bit, max 9799) and idx_valid SHALL be 1.
REQ-019 idx and idx_valid SHALL hold stable until idx_valid and idx_ready are both high at a rising edge.
REQ-020 On that handshake the block SHALL clear the emitted bit in the working register, increment count, and return to SCAN_GRP with grp_ptr unchanged.
REQ-021 Indices SHALL be emitted in strictly ascending order, each set bit exactly once.
REQ-022 DONE SHALL last one cycle with done=1 and count held, then return to IDLE. count SHALL hold until the next accepted start.
REQ-023 start SHALL be ignored while busy=1. vector changes after acceptance SHALL have no effect.
REQ-024 Latency: for a start accepted at edge k with bit 0 set, idx_valid=1, idx=0 SHALL appear in the cycle after edge k+3.
REQ-025 An all-zero vector SHALL produce done after exactly 70 SCAN_SEG cycles, with count=0 and no idx_valid.
REQ-026 idx_valid SHALL be 0 in every state except EMIT.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE from any state, including mid-EMIT.
REQ-028 Reset values SHALL be: idx=0, idx_valid=0, done=0, busy=0, count=0, all pointers 0, working register all-zero.
REQ-029 A pending emit SHALL be discarded on reset, with no handshake implied.

Structure
REQ-030 A shared package SHALL hold N_BITS, SEG_BITS, GRP_BITS, N_SEG=70, N_GRP=14, IDX_W=14, and the state encoding.
REQ-031 Segment extraction plus OR-reduce SHALL be one combinational sub-module, vec_seg_select: a 140-bit slice selected by seg_ptr, with any-bit outputs per segment and per group.
REQ-032 The index computation SHALL use registered pointers only; no combinational path from idx_ready to idx.

Verification
REQ-033 A single bit at 0 with idx_ready tied high SHALL give idx=0 four cycles after start, followed by done with count=1.
REQ-034 A single bit at 9799 SHALL give idx=9799, then done with count=1.
REQ-035 Bits {0,10,139,140,9790} with idx_ready=1 SHALL emit 0,10,139,140,9790 in order, then done with count=5.
REQ-036 An all-zero vector SHALL give done exactly 71 cycles after the start edge, with count=0 and idx_valid never asserted.
REQ-037 Bits {5,6} with idx_ready low for 8 cycles SHALL hold idx=5 and idx_valid=1 for all 8 cycles, then emit 6 once ready rises; a second start while busy SHALL be ignored.
REQ-038 rst asserted during EMIT of idx=140 SHALL give idx_valid=0, busy=0, count=0 next cycle; a fresh start SHALL then decode normally.
